vx_om_bus_serializer: RTL and testbench

// - Slave end of the OM request bus: accepts one multi-lane OM request (uuid, mask, per-lane pos/color/depth/face).
// - Emits one fragment per active lane, lowest lane index first, on a valid/ready stream into the single-lane OM pipeline.
// - Sits between the core-side OM bus arbiter and the OM blend/depth datapath.

---
 rtl/vx_om_pkg.sv | 33 +++
 rtl/vx_om_lane_pick.sv | 38 +++
 rtl/vx_om_bus_serializer.sv | 136 +++++++++++++
 tb/tb_vx_om_bus_serializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vx_om_pkg.sv
// Shared types for the OM request-bus serializer: fragment record and FSM states.
// Field widths here define the default configuration of the serializer.
package vx_om_pkg;

  localparam int OM_NUM_LANES  = 4;
  localparam int OM_UUID_WIDTH = 44;
  localparam int OM_DIM_BITS   = 11;
  localparam int OM_DEPTH_BITS = 24;
  localparam int OM_COLOR_BITS = 32;

  function automatic int om_lane_bits(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  localparam int OM_LANE_BITS = om_lane_bits(OM_NUM_LANES);

  typedef struct packed {
    logic [OM_UUID_WIDTH-1:0] uuid;
    logic [OM_LANE_BITS-1:0]  lane;
    logic [OM_DIM_BITS-1:0]   pos_x;
    logic [OM_DIM_BITS-1:0]   pos_y;
    logic [OM_COLOR_BITS-1:0] color;
    logic [OM_DEPTH_BITS-1:0] depth;
    logic                     face;
    logic                     last;
  } om_frag_t;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_BUSY = 1'b1
  } ser_state_e;

endpackage

// File: rtl/vx_om_lane_pick.sv
// Combinational lowest-set-bit finder over a lane mask: index, one-hot and
// a flag telling whether that bit is the only one set.
module vx_om_lane_pick
  import vx_om_pkg::*;
#(
  parameter int NUM_LANES = OM_NUM_LANES,
  parameter int LANE_W    = om_lane_bits(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] mask,
  output logic [LANE_W-1:0]    index,
  output logic [NUM_LANES-1:0] onehot,
  output logic                 is_single
);

  // seen[k] is set when any lane below k is active
  logic [NUM_LANES-1:0] seen;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign seen[gi] = 1'b0;
      end else begin : g_rest
        assign seen[gi] = seen[gi-1] | mask[gi-1];
      end
      assign onehot[gi] = mask[gi] & ~seen[gi];
    end
  endgenerate

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (onehot[i]) index = index | i[LANE_W-1:0];
    end
  end

  assign is_single = (|mask) && (mask == onehot);

endmodule

// File: rtl/vx_om_bus_serializer.sv
// Accepts one multi-lane OM request and streams one fragment per active lane,
// lowest lane first, into the single-lane OM pipeline.
module vx_om_bus_serializer
  import vx_om_pkg::*;
#(
  parameter int NUM_LANES  = OM_NUM_LANES,
  parameter int UUID_WIDTH = OM_UUID_WIDTH,
  parameter int DIM_BITS   = OM_DIM_BITS,
  parameter int DEPTH_BITS = OM_DEPTH_BITS,
  parameter int COLOR_BITS = OM_COLOR_BITS,
  parameter int LANE_W     = om_lane_bits(NUM_LANES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  input  logic [UUID_WIDTH-1:0]           req_uuid,
  input  logic [NUM_LANES-1:0]            req_mask,
  input  logic [NUM_LANES*DIM_BITS-1:0]   req_pos_x,
  input  logic [NUM_LANES*DIM_BITS-1:0]   req_pos_y,
  input  logic [NUM_LANES*COLOR_BITS-1:0] req_color,
  input  logic [NUM_LANES*DEPTH_BITS-1:0] req_depth,
  input  logic [NUM_LANES-1:0]            req_face,
  output logic                            req_ready,
  output logic                            frag_valid,
  output logic [UUID_WIDTH-1:0]           frag_uuid,
  output logic [LANE_W-1:0]               frag_lane,
  output logic [DIM_BITS-1:0]             frag_pos_x,
  output logic [DIM_BITS-1:0]             frag_pos_y,
  output logic [COLOR_BITS-1:0]           frag_color,
  output logic [DEPTH_BITS-1:0]           frag_depth,
  output logic                            frag_face,
  output logic                            frag_last,
  input  logic                            frag_ready
);

  ser_state_e state_reg, state_next;
  logic [NUM_LANES-1:0] pending_reg, pending_next;
  logic                 load_req;

  logic [UUID_WIDTH-1:0]           uuid_reg;
  logic [NUM_LANES*DIM_BITS-1:0]   pos_x_reg, pos_y_reg;
  logic [NUM_LANES*COLOR_BITS-1:0] color_reg;
  logic [NUM_LANES*DEPTH_BITS-1:0] depth_reg;
  logic [NUM_LANES-1:0]            face_reg;

  logic [LANE_W-1:0]    lane_idx;
  logic [NUM_LANES-1:0] lane_onehot;
  logic                 lane_single;
  logic                 req_fire;
  logic                 frag_fire;
  om_frag_t             frag;

  vx_om_lane_pick #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_lane_pick (
    .mask      (pending_reg),
    .index     (lane_idx),
    .onehot    (lane_onehot),
    .is_single (lane_single)
  );

  assign frag_valid = (state_reg == SER_BUSY);
  assign frag_fire  = frag_valid & frag_ready;
  // Accepting on the last fragment's transfer keeps back-to-back requests bubble-free
  assign req_ready  = reset & ((state_reg == SER_IDLE) | (frag_fire & lane_single));
  assign req_fire   = req_valid & req_ready;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    load_req     = 1'b0;
    unique case (state_reg)
      SER_IDLE: begin
      end
      SER_BUSY: begin
        if (frag_fire) begin
          if (lane_single) begin
            pending_next = '0;
            state_next   = SER_IDLE;
          end else begin
            pending_next = pending_reg & ~lane_onehot;
          end
        end
      end
      default: state_next = SER_IDLE;
    endcase
    if (req_fire) begin
      load_req     = 1'b1;
      pending_next = req_mask;
      state_next   = (|req_mask) ? SER_BUSY : SER_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= SER_IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge clk) begin
    if (load_req) begin
      uuid_reg  <= req_uuid;
      pos_x_reg <= req_pos_x;
      pos_y_reg <= req_pos_y;
      color_reg <= req_color;
      depth_reg <= req_depth;
      face_reg  <= req_face;
    end
  end

  always_comb begin
    frag.uuid  = uuid_reg;
    frag.lane  = lane_idx;
    frag.pos_x = pos_x_reg[lane_idx*DIM_BITS +: DIM_BITS];
    frag.pos_y = pos_y_reg[lane_idx*DIM_BITS +: DIM_BITS];
    frag.color = color_reg[lane_idx*COLOR_BITS +: COLOR_BITS];
    frag.depth = depth_reg[lane_idx*DEPTH_BITS +: DEPTH_BITS];
    frag.face  = face_reg[lane_idx];
    frag.last  = frag_valid & lane_single;
  end

  assign frag_uuid  = frag.uuid;
  assign frag_lane  = frag.lane;
  assign frag_pos_x = frag.pos_x;
  assign frag_pos_y = frag.pos_y;
  assign frag_color = frag.color;
  assign frag_depth = frag.depth;
  assign frag_face  = frag.face;
  assign frag_last  = frag.last;

endmodule

// File: tb/tb_vx_om_bus_serializer.sv
// Directed plus randomized bench for the OM bus serializer; expectations come
// from a queue of fragments derived from each accepted request's mask.
module tb_vx_om_bus_serializer;

  localparam int N   = 4;
  localparam int UW  = 44;
  localparam int DB  = 11;
  localparam int DPB = 24;
  localparam int CB  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [UW-1:0]     req_uuid;
  logic [N-1:0]      req_mask;
  logic [N*DB-1:0]   req_pos_x, req_pos_y;
  logic [N*CB-1:0]   req_color;
  logic [N*DPB-1:0]  req_depth;
  logic [N-1:0]      req_face;
  logic              req_ready;
  logic              frag_valid;
  logic [UW-1:0]     frag_uuid;
  logic [1:0]        frag_lane;
  logic [DB-1:0]     frag_pos_x, frag_pos_y;
  logic [CB-1:0]     frag_color;
  logic [DPB-1:0]    frag_depth;
  logic              frag_face;
  logic              frag_last;
  logic              frag_ready;

  vx_om_bus_serializer #(
    .NUM_LANES(N), .UUID_WIDTH(UW), .DIM_BITS(DB), .DEPTH_BITS(DPB), .COLOR_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_uuid(req_uuid), .req_mask(req_mask),
    .req_pos_x(req_pos_x), .req_pos_y(req_pos_y), .req_color(req_color),
    .req_depth(req_depth), .req_face(req_face), .req_ready(req_ready),
    .frag_valid(frag_valid), .frag_uuid(frag_uuid), .frag_lane(frag_lane),
    .frag_pos_x(frag_pos_x), .frag_pos_y(frag_pos_y), .frag_color(frag_color),
    .frag_depth(frag_depth), .frag_face(frag_face), .frag_last(frag_last),
    .frag_ready(frag_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [UW-1:0]  uuid;
    logic [1:0]     lane;
    logic [DB-1:0]  x;
    logic [DB-1:0]  y;
    logic [CB-1:0]  color;
    logic [DPB-1:0] depth;
    logic           face;
    logic           last;
  } exp_frag_t;

  exp_frag_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A request expands into its active lanes in ascending order; the highest one is last
  task automatic push_req();
    exp_frag_t f;
    for (int i = 0; i < N; i++) begin
      if (req_mask[i]) begin
        f.uuid  = req_uuid;
        f.lane  = 2'(i);
        f.x     = req_pos_x[i*DB +: DB];
        f.y     = req_pos_y[i*DB +: DB];
        f.color = req_color[i*CB +: CB];
        f.depth = req_depth[i*DPB +: DPB];
        f.face  = req_face[i];
        f.last  = ((req_mask >> (i + 1)) == '0);
        exp_q.push_back(f);
      end
    end
  endtask

  // One clock: check outputs, advance the model across the posedge, return at negedge
  task automatic step();
    exp_frag_t e;
    bit ev, er;
    #1;
    ev = (exp_q.size() != 0);
    er = reset && ((exp_q.size() == 0) || (frag_ready && exp_q.size() == 1));
    chk("frag_valid", 64'(frag_valid), 64'(ev));
    chk("req_ready", 64'(req_ready), 64'(er));
    if (ev) begin
      e = exp_q[0];
      chk("frag_uuid", 64'(frag_uuid), 64'(e.uuid));
      chk("frag_lane", 64'(frag_lane), 64'(e.lane));
      chk("frag_pos_x", 64'(frag_pos_x), 64'(e.x));
      chk("frag_pos_y", 64'(frag_pos_y), 64'(e.y));
      chk("frag_color", 64'(frag_color), 64'(e.color));
      chk("frag_depth", 64'(frag_depth), 64'(e.depth));
      chk("frag_face", 64'(frag_face), 64'(e.face));
      chk("frag_last", 64'(frag_last), 64'(e.last));
    end else begin
      chk("frag_last_idle", 64'(frag_last), 64'(0));
    end
    @(posedge clk);
    last_acc = 1'b0;
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (ev && frag_ready) begin
        $display("frag uuid=%0h lane=%0d last=%0b", e.uuid, e.lane, e.last);
        exp_q.delete(0);
      end
      if (req_valid && er) begin
        $display("req  uuid=%0h mask=%b accepted", req_uuid, req_mask);
        push_req();
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input logic [UW-1:0] uuid, input logic [N-1:0] mask, input bit pattern);
    req_uuid = uuid;
    req_mask = mask;
    for (int i = 0; i < N; i++) begin
      req_color[i*CB +: CB] = $urandom;
      if (pattern) begin
        req_pos_x[i*DB +: DB]   = DB'(i);
        req_pos_y[i*DB +: DB]   = DB'(10 + i);
        req_depth[i*DPB +: DPB] = DPB'(100 + i);
        req_face[i]             = i[0];
      end else begin
        req_pos_x[i*DB +: DB]   = DB'($urandom);
        req_pos_y[i*DB +: DB]   = DB'($urandom);
        req_depth[i*DPB +: DPB] = DPB'($urandom);
        req_face[i]             = 1'($urandom);
      end
    end
  endtask

  task automatic send(input logic [UW-1:0] uuid, input logic [N-1:0] mask, input bit pattern,
                      input bit rand_ready);
    int n = 0;
    set_req(uuid, mask, pattern);
    req_valid = 1'b1;
    last_acc  = 1'b0;
    while (!last_acc && n < 40) begin
      if (rand_ready) frag_ready = 1'($urandom);
      step();
      n++;
    end
    chk("accept_timeout", 64'(last_acc), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int n = 0;
    frag_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      if (rand_ready) frag_ready = 1'($urandom);
      step();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    frag_ready = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    frag_ready = 1'b1;
    set_req('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();                 // still in reset: no output, req_ready low
    reset = 1'b1;
    step();                 // idle: req_ready high

    // Sparse mask, always ready
    send(44'h1, 4'b1011, 1'b0, 1'b0);
    drain(1'b0);
    step();

    // Downstream stall: lane 1 must hold while ready is low
    frag_ready = 1'b0;
    send(44'h2, 4'b0110, 1'b0, 1'b0);
    repeat (5) step();
    drain(1'b0);

    // Back-to-back: second request accepted on the first's last fragment
    send(44'h7, 4'b1111, 1'b0, 1'b0);
    send(44'h8, 4'b0001, 1'b0, 1'b0);
    drain(1'b0);

    // Zero-mask requests are swallowed one per cycle
    send(44'h9, 4'b0000, 1'b0, 1'b0);
    send(44'hA, 4'b0000, 1'b0, 1'b0);
    send(44'hB, 4'b0000, 1'b0, 1'b0);
    step();

    // Reset mid-request after lane 0
    send(44'hC, 4'b1111, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();

    // Per-lane field pattern
    send(44'hD, 4'b1111, 1'b1, 1'b0);
    drain(1'b0);

    // Randomized traffic with random backpressure and random gaps
    for (int t = 0; t < 40; t++) begin
      send({12'h0, 32'($urandom)}, 4'($urandom), 1'b0, 1'b1);
      if ($urandom_range(0, 2) == 0) drain(1'b1);
      if ($urandom_range(0, 3) == 0) step();
    end
    drain(1'b1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
